// File: rtl/playfield_pkg.sv
// Shared constants and types for the playfield renderer.
package playfield_pkg;

    // Scan FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LBORDER  = 3'd1;
    localparam logic [2:0] ST_PF_LEFT  = 3'd2;
    localparam logic [2:0] ST_PF_RIGHT = 3'd3;
    localparam logic [2:0] ST_RBORDER  = 3'd4;

    // Register map
    localparam logic [2:0] ADDR_PF0    = 3'd0;
    localparam logic [2:0] ADDR_PF1    = 3'd1;
    localparam logic [2:0] ADDR_PF2    = 3'd2;
    localparam logic [2:0] ADDR_PF3    = 3'd3;
    localparam logic [2:0] ADDR_FG     = 3'd4;
    localparam logic [2:0] ADDR_BG     = 3'd5;
    localparam logic [2:0] ADDR_BORDER = 3'd6;
    localparam logic [2:0] ADDR_CTRL   = 3'd7;

    // Control register bit positions
    localparam int unsigned CTRL_REFLECT   = 0;
    localparam int unsigned CTRL_IMMEDIATE = 1;

    // CPU-visible shadow register set
    typedef struct packed {
        logic [31:0] pf;
        logic [6:0]  fg;
        logic [6:0]  bg;
        logic [6:0]  border;
        logic [1:0]  ctrl;
    } pf_regs_t;

endpackage

// File: rtl/playfield_regs.sv
// Shadow/active register file: CPU writes land in the shadow set, which is
// copied to the active set on the hblank rising edge (or every cycle in
// immediate mode) so a line never tears.
module playfield_regs
    import playfield_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        write_enable_i,
    input  logic [2:0]  address_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    input  logic        hblank_i,
    output logic [31:0] pf_o,
    output logic [6:0]  fg_o,
    output logic [6:0]  bg_o,
    output logic [6:0]  border_o,
    output logic        reflect_o
);

    pf_regs_t    shadow_q, shadow_d;
    logic [31:0] pf_a_q;
    logic [6:0]  fg_a_q, bg_a_q, border_a_q;
    logic        reflect_a_q;
    logic        hblank_q;
    logic [7:0]  rdata;
    logic        transfer;

    // Active set samples the pre-write shadow, so an edge-cycle write waits a line
    assign transfer = shadow_q.ctrl[CTRL_IMMEDIATE] | (hblank_i & ~hblank_q);

    // Shadow next-state from CPU writes
    always_comb begin
        shadow_d = shadow_q;
        if (enable_i && write_enable_i) begin
            case (address_i)
                ADDR_PF0:    shadow_d.pf[7:0]   = data_i;
                ADDR_PF1:    shadow_d.pf[15:8]  = data_i;
                ADDR_PF2:    shadow_d.pf[23:16] = data_i;
                ADDR_PF3:    shadow_d.pf[31:24] = data_i;
                ADDR_FG:     shadow_d.fg        = data_i[7:1];
                ADDR_BG:     shadow_d.bg        = data_i[7:1];
                ADDR_BORDER: shadow_d.border    = data_i[7:1];
                default:     shadow_d.ctrl      = data_i[1:0];
            endcase
        end
    end

    // Read mux over the shadow set
    always_comb begin
        rdata = 8'h00;
        case (address_i)
            ADDR_PF0:    rdata = shadow_q.pf[7:0];
            ADDR_PF1:    rdata = shadow_q.pf[15:8];
            ADDR_PF2:    rdata = shadow_q.pf[23:16];
            ADDR_PF3:    rdata = shadow_q.pf[31:24];
            ADDR_FG:     rdata = {shadow_q.fg, 1'b0};
            ADDR_BG:     rdata = {shadow_q.bg, 1'b0};
            ADDR_BORDER: rdata = {shadow_q.border, 1'b0};
            default:     rdata = {6'b0, shadow_q.ctrl};
        endcase
    end

    // Register state: shadow, active, hblank history and read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q    <= '0;
            pf_a_q      <= '0;
            fg_a_q      <= '0;
            bg_a_q      <= '0;
            border_a_q  <= '0;
            reflect_a_q <= 1'b0;
            hblank_q    <= 1'b0;
            data_o      <= 8'h00;
        end else begin
            shadow_q <= shadow_d;
            hblank_q <= hblank_i;
            if (transfer) begin
                pf_a_q      <= shadow_q.pf;
                fg_a_q      <= shadow_q.fg;
                bg_a_q      <= shadow_q.bg;
                border_a_q  <= shadow_q.border;
                reflect_a_q <= shadow_q.ctrl[CTRL_REFLECT];
            end
            if (enable_i && !write_enable_i) begin
                data_o <= rdata;
            end
        end
    end

    assign pf_o      = pf_a_q;
    assign fg_o      = fg_a_q;
    assign bg_o      = bg_a_q;
    assign border_o  = border_a_q;
    assign reflect_o = reflect_a_q;

endmodule

// File: rtl/playfield_engine.sv
// Playfield renderer top: scan FSM walking border / left half / right half
// on each pixel strobe, and the registered colour output.
module playfield_engine
    import playfield_pkg::*;
#(
    parameter int unsigned PF_BITS        = 20,
    parameter int unsigned PIXELS_PER_BIT = 16,
    parameter int unsigned LEFT_BORDER    = 40,
    parameter int unsigned COLOR_WIDTH    = 7
) (
    input  logic                   raw_clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   write_enable,
    input  logic [2:0]             address,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic                   pixel_en,
    input  logic                   in_image,
    input  logic                   in_hblank,
    output logic [COLOR_WIDTH-1:0] color,
    output logic                   is_fg
);

    logic [31:0] pf_a;
    logic [6:0]  fg_a, bg_a, border_a;
    logic        reflect_a;

    playfield_regs u_regs (
        .clk_i          (raw_clk),
        .rst_i          (reset),
        .enable_i       (enable),
        .write_enable_i (write_enable),
        .address_i      (address),
        .data_i         (data_in),
        .data_o         (data_out),
        .hblank_i       (in_hblank),
        .pf_o           (pf_a),
        .fg_o           (fg_a),
        .bg_o           (bg_a),
        .border_o       (border_a),
        .reflect_o      (reflect_a)
    );

    logic [2:0]             state_q, state_d, cur_state;
    logic [15:0]            pix_cnt_q, pix_cnt_d, cur_pix;
    logic [4:0]             bit_idx_q, bit_idx_d, cur_bit;
    logic [5:0]             sub_cnt_q, sub_cnt_d, cur_sub;
    logic                   armed_q, armed_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic                   is_fg_q, is_fg_d;
    logic [4:0]             pf_idx;
    logic                   pix_fg;
    logic [6:0]             pix_color;

    // Position of the pixel being sampled; from IDLE this is the line's first pixel
    always_comb begin
        cur_state = state_q;
        cur_pix   = pix_cnt_q;
        cur_bit   = bit_idx_q;
        cur_sub   = sub_cnt_q;
        if (state_q == ST_IDLE) begin
            cur_state = (LEFT_BORDER == 0) ? ST_PF_LEFT : ST_LBORDER;
            cur_pix   = '0;
            cur_bit   = '0;
            cur_sub   = '0;
        end
    end

    // Colour of the sampled pixel
    always_comb begin
        pf_idx    = cur_bit;
        pix_fg    = 1'b0;
        pix_color = 7'd0;
        if ((cur_state == ST_PF_RIGHT) && reflect_a) begin
            pf_idx = 5'(PF_BITS - 1) - cur_bit;
        end
        case (cur_state)
            ST_LBORDER, ST_RBORDER: pix_color = border_a;
            ST_PF_LEFT, ST_PF_RIGHT: begin
                pix_fg    = pf_a[pf_idx];
                pix_color = pix_fg ? fg_a : bg_a;
            end
            default: pix_color = 7'd0;
        endcase
    end

    // Scan FSM next-state, advancing only on pixel strobes
    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        bit_idx_d = bit_idx_q;
        sub_cnt_d = sub_cnt_q;
        armed_d   = armed_q;
        color_d   = color_q;
        is_fg_d   = is_fg_q;
        if (pixel_en) begin
            if (!in_image) begin
                state_d   = ST_IDLE;
                pix_cnt_d = '0;
                bit_idx_d = '0;
                sub_cnt_d = '0;
                armed_d   = 1'b1;
                color_d   = '0;
                is_fg_d   = 1'b0;
            end else if ((state_q != ST_IDLE) || armed_q) begin
                color_d   = COLOR_WIDTH'(pix_color);
                is_fg_d   = pix_fg;
                state_d   = cur_state;
                pix_cnt_d = cur_pix;
                bit_idx_d = cur_bit;
                sub_cnt_d = cur_sub;
                case (cur_state)
                    ST_LBORDER: begin
                        if (cur_pix == 16'(LEFT_BORDER - 1)) begin
                            state_d   = ST_PF_LEFT;
                            bit_idx_d = '0;
                            sub_cnt_d = '0;
                        end else begin
                            pix_cnt_d = cur_pix + 16'd1;
                        end
                    end
                    ST_PF_LEFT, ST_PF_RIGHT: begin
                        if (cur_sub == 6'(PIXELS_PER_BIT - 1)) begin
                            sub_cnt_d = '0;
                            if (cur_bit == 5'(PF_BITS - 1)) begin
                                bit_idx_d = '0;
                                state_d   = (cur_state == ST_PF_LEFT) ? ST_PF_RIGHT
                                                                      : ST_RBORDER;
                            end else begin
                                bit_idx_d = cur_bit + 5'd1;
                            end
                        end else begin
                            sub_cnt_d = cur_sub + 6'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM and output registers; outputs drop at once on reset
    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pix_cnt_q <= '0;
            bit_idx_q <= '0;
            sub_cnt_q <= '0;
            armed_q   <= 1'b0;
            color_q   <= '0;
            is_fg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            bit_idx_q <= bit_idx_d;
            sub_cnt_q <= sub_cnt_d;
            armed_q   <= armed_d;
            color_q   <= color_d;
            is_fg_q   <= is_fg_d;
        end
    end

    assign color = color_q;
    assign is_fg = is_fg_q;

endmodule
